// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the multi-cycle core control path.
//   state_e    : sequencer FSM states
//   op_class_e : coarse instruction class derived from the 6-bit opcode
//   OP_*       : legal opcode encodings
//   PC_SEL_*   : PC mux select codes driven to the datapath
//   FAULT_*    : fault_code values
//   classify_op: opcode -> op_class_e (CLS_ILLEGAL for anything not listed)
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_FAULT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ILLEGAL,
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_JAL
   } op_class_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] PC_SEL_INC = 2'd0;
   localparam logic [1:0] PC_SEL_BR  = 2'd1;
   localparam logic [1:0] PC_SEL_JMP = 2'd2;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_IMEM_TO = 2'd2;
   localparam logic [1:0] FAULT_DMEM_TO = 2'd3;

   function automatic op_class_e classify_op(input logic [5:0] op);
      op_class_e cls;
      case (op)
         OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LUI:          cls = CLS_ALU;
         OP_LW:                            cls = CLS_LOAD;
         OP_SW:                            cls = CLS_STORE;
         OP_BEQ, OP_BNE:                   cls = CLS_BRANCH;
         OP_J:                             cls = CLS_JUMP;
         OP_JAL:                           cls = CLS_JAL;
         default:                          cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// wait_timer: memory-handshake wait counter shared by FETCH and MEM.
//   clk, rstn  : clock, asynchronous active-low reset
//   clr_i      : restart the count at 0 (entry to a waiting state)
//   cnt_en_i   : a request cycle passed without ack
//   timeout_o  : this cycle is the LIMIT-th consecutive cycle without ack
// LIMIT = 0 disables the timeout entirely.
module wait_timer #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic timeout_o
);

   localparam int unsigned TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [TW-1:0] LAST = (LIMIT == 0) ? '0 : TW'(LIMIT - 1);
   localparam logic ENABLED = (LIMIT != 0);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ENABLED && cnt_en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // cnt_q counts previous ack-less cycles, so reaching LAST with no ack
   // now means LIMIT request cycles have elapsed. An ack masks cnt_en_i,
   // which makes an ack on the limit cycle win.
   assign timeout_o = ENABLED && cnt_en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the core datapath.
//   clk, rstn          : clock, asynchronous active-low reset
//   run                : keep executing (sampled in IDLE and at retire)
//   opecode            : opcode of the latched instruction (read in DECODE)
//   branch_taken       : ALU compare result, used in EXEC
//   imem_req/imem_ack  : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack : data access handshake (we=1 store)
//   ir_we, pc_we, pc_sel, lr_we, rf_we, mem_to_reg : datapath controls
//   busy, retire, instret : status, retire pulse, retired count
//   fault, fault_code  : sticky fault flag and cause
module multicycle_sequencer
   import core_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   input  logic [5:0]       opecode,
   input  logic             branch_taken,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             lr_we,
   output logic             rf_we,
   output logic             mem_to_reg,
   output logic             busy,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             fault,
   output logic [1:0]       fault_code
);

   state_e     state_q, state_d;
   op_class_e  cls_q, cls_d;
   logic [1:0] fault_code_q, fault_code_d;
   logic [CNT_W-1:0] instret_q;

   logic tmr_clr, tmr_en, tmr_timeout;
   state_e next_instr;

   wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rstn      (rstn),
      .clr_i     (tmr_clr),
      .cnt_en_i  (tmr_en),
      .timeout_o (tmr_timeout)
   );

   assign next_instr = run ? ST_FETCH : ST_IDLE;

   // The timer restarts on every transition into a waiting state and only
   // advances while the active request is still unacknowledged.
   assign tmr_clr = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                    ((state_d == ST_MEM)   && (state_q != ST_MEM));
   assign tmr_en  = ((state_q == ST_FETCH) && !imem_ack) ||
                    ((state_q == ST_MEM)   && !dmem_ack);

   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      fault_code_d = fault_code_q;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_SEL_INC;
      lr_we        = 1'b0;
      rf_we        = 1'b0;
      mem_to_reg   = 1'b0;
      busy         = 1'b0;
      retire       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            busy     = 1'b1;
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (tmr_timeout) begin
               state_d      = ST_FAULT;
               fault_code_d = FAULT_IMEM_TO;
            end
         end
         ST_DECODE: begin
            busy = 1'b1;
            // Class is captured here so later states do not depend on
            // opecode staying stable for the rest of the instruction.
            cls_d = classify_op(opecode);
            if (cls_d == CLS_ILLEGAL) begin
               state_d      = ST_FAULT;
               fault_code_d = FAULT_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy = 1'b1;
            case (cls_q)
               CLS_ALU:              state_d = ST_WB;
               CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
               CLS_BRANCH: begin
                  pc_we   = 1'b1;
                  pc_sel  = branch_taken ? PC_SEL_BR : PC_SEL_INC;
                  retire  = 1'b1;
                  state_d = next_instr;
               end
               CLS_JUMP, CLS_JAL: begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_SEL_JMP;
                  lr_we   = (cls_q == CLS_JAL);
                  retire  = 1'b1;
                  state_d = next_instr;
               end
               default: begin
                  state_d      = ST_FAULT;
                  fault_code_d = FAULT_ILLEGAL;
               end
            endcase
         end
         ST_MEM: begin
            busy     = 1'b1;
            dmem_req = 1'b1;
            dmem_we  = (cls_q == CLS_STORE);
            if (dmem_ack) begin
               if (cls_q == CLS_STORE) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = next_instr;
               end else begin
                  state_d = ST_WB;
               end
            end else if (tmr_timeout) begin
               state_d      = ST_FAULT;
               fault_code_d = FAULT_DMEM_TO;
            end
         end
         ST_WB: begin
            busy       = 1'b1;
            rf_we      = 1'b1;
            mem_to_reg = (cls_q == CLS_LOAD);
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_d    = next_instr;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         cls_q        <= CLS_ILLEGAL;
         fault_code_q <= FAULT_NONE;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         cls_q        <= cls_d;
         fault_code_q <= fault_code_d;
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign instret    = instret_q;
   assign fault      = (state_q == ST_FAULT);
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed table-driven bench for multicycle_sequencer (MEM_TIMEOUT=4,
// CNT_W=3 so the retired counter wraps within a short run).
module tb_multicycle_sequencer;

   logic       clk = 1'b0;
   logic       rstn, run, branch_taken, imem_ack, dmem_ack;
   logic [5:0] opecode;
   logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, lr_we, rf_we;
   logic       mem_to_reg, busy, retire, fault;
   logic [1:0] pc_sel, fault_code;
   logic [2:0] instret;

   multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .run          (run),
      .opecode      (opecode),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .lr_we        (lr_we),
      .rf_we        (rf_we),
      .mem_to_reg   (mem_to_reg),
      .busy         (busy),
      .retire       (retire),
      .instret      (instret),
      .fault        (fault),
      .fault_code   (fault_code)
   );

   always #5 clk = ~clk;

   // Output vector order:
   // imem_req dmem_req dmem_we ir_we pc_we pc_sel[2] lr_we rf_we mem_to_reg
   // busy retire fault fault_code[2]
   logic [14:0] got;
   assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, lr_we,
                 rf_we, mem_to_reg, busy, retire, fault, fault_code};

   localparam logic [14:0] IDL = 15'b0_0_0_0_0_00_0_0_0_0_0_0_00;
   localparam logic [14:0] F   = 15'b1_0_0_0_0_00_0_0_0_1_0_0_00;
   localparam logic [14:0] FA  = 15'b1_0_0_1_0_00_0_0_0_1_0_0_00;
   localparam logic [14:0] B   = 15'b0_0_0_0_0_00_0_0_0_1_0_0_00;
   localparam logic [14:0] EB0 = 15'b0_0_0_0_1_00_0_0_0_1_1_0_00;
   localparam logic [14:0] EB1 = 15'b0_0_0_0_1_01_0_0_0_1_1_0_00;
   localparam logic [14:0] EJ  = 15'b0_0_0_0_1_10_0_0_0_1_1_0_00;
   localparam logic [14:0] EJL = 15'b0_0_0_0_1_10_1_0_0_1_1_0_00;
   localparam logic [14:0] ML  = 15'b0_1_0_0_0_00_0_0_0_1_0_0_00;
   localparam logic [14:0] MS  = 15'b0_1_1_0_0_00_0_0_0_1_0_0_00;
   localparam logic [14:0] MSA = 15'b0_1_1_0_1_00_0_0_0_1_1_0_00;
   localparam logic [14:0] WA  = 15'b0_0_0_0_1_00_0_1_0_1_1_0_00;
   localparam logic [14:0] WL  = 15'b0_0_0_0_1_00_0_1_1_1_1_0_00;
   localparam logic [14:0] FT1 = 15'b0_0_0_0_0_00_0_0_0_0_0_1_01;
   localparam logic [14:0] FT2 = 15'b0_0_0_0_0_00_0_0_0_0_0_1_10;
   localparam logic [14:0] FT3 = 15'b0_0_0_0_0_00_0_0_0_0_0_1_11;

   typedef struct {
      logic        rn;
      logic        run;
      logic [5:0]  op;
      logic        bt;
      logic        ia;
      logic        da;
      logic [14:0] exp;
      logic [2:0]  ic;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(input logic rn, input logic rr, input logic [5:0] op,
                               input logic bt, input logic ia, input logic da,
                               input logic [14:0] exp, input logic [2:0] ic);
      vec_t v;
      v.rn = rn; v.run = rr; v.op = op; v.bt = bt; v.ia = ia; v.da = da;
      v.exp = exp; v.ic = ic;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int row,
                        input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
      end
   endtask

   initial begin
      // reset, then R-type with zero-wait fetch
      add(0,0,6'h00,0,0,0,IDL,0);
      add(1,1,6'h00,0,1,0,IDL,0);
      add(1,1,6'h00,0,1,0,FA ,0);
      add(1,1,6'h00,0,1,0,B  ,0);
      add(1,1,6'h00,0,1,0,B  ,0);
      add(1,1,6'h00,0,1,0,WA ,0);
      // lw with dmem_ack on the 4th request cycle (also the timeout limit)
      add(1,1,6'h23,0,1,0,FA ,1);
      add(1,1,6'h23,0,1,0,B  ,1);
      add(1,1,6'h23,0,1,0,B  ,1);
      add(1,1,6'h23,0,1,0,ML ,1);
      add(1,1,6'h23,0,1,0,ML ,1);
      add(1,1,6'h23,0,1,0,ML ,1);
      add(1,1,6'h23,0,1,1,ML ,1);
      add(1,1,6'h23,0,1,0,WL ,1);
      // sw, one wait cycle
      add(1,1,6'h2B,0,1,0,FA ,2);
      add(1,1,6'h2B,0,1,0,B  ,2);
      add(1,1,6'h2B,0,1,0,B  ,2);
      add(1,1,6'h2B,0,1,0,MS ,2);
      add(1,1,6'h2B,0,1,1,MSA,2);
      // beq taken / not taken, jal, j, bne taken (instret wraps 7 -> 0)
      add(1,1,6'h04,1,1,0,FA ,3);
      add(1,1,6'h04,1,1,0,B  ,3);
      add(1,1,6'h04,1,1,0,EB1,3);
      add(1,1,6'h04,0,1,0,FA ,4);
      add(1,1,6'h04,0,1,0,B  ,4);
      add(1,1,6'h04,0,1,0,EB0,4);
      add(1,1,6'h03,0,1,0,FA ,5);
      add(1,1,6'h03,0,1,0,B  ,5);
      add(1,1,6'h03,0,1,0,EJL,5);
      add(1,1,6'h02,0,1,0,FA ,6);
      add(1,1,6'h02,0,1,0,B  ,6);
      add(1,1,6'h02,0,1,0,EJ ,6);
      add(1,1,6'h05,1,1,0,FA ,7);
      add(1,1,6'h05,1,1,0,B  ,7);
      add(1,1,6'h05,1,1,0,EB1,7);
      // addi, run dropped in EXEC: completes then idles
      add(1,1,6'h08,0,1,0,FA ,0);
      add(1,1,6'h08,0,1,0,B  ,0);
      add(1,0,6'h08,0,1,0,B  ,0);
      add(1,0,6'h08,0,1,0,WA ,0);
      add(1,0,6'h08,0,1,0,IDL,1);
      add(1,0,6'h08,0,1,0,IDL,1);
      // fetch timeout after 4 request cycles; late ack ignored in FAULT
      add(1,1,6'h00,0,0,0,IDL,1);
      add(1,1,6'h00,0,0,0,F  ,1);
      add(1,1,6'h00,0,0,0,F  ,1);
      add(1,1,6'h00,0,0,0,F  ,1);
      add(1,1,6'h00,0,0,0,F  ,1);
      add(1,1,6'h00,0,0,0,FT2,1);
      add(1,1,6'h00,0,1,1,FT2,1);
      // reset, fetch ack on the 4th cycle wins, then illegal opcode
      add(0,1,6'h3F,0,0,0,IDL,0);
      add(1,1,6'h3F,0,0,0,IDL,0);
      add(1,1,6'h3F,0,0,0,F  ,0);
      add(1,1,6'h3F,0,0,0,F  ,0);
      add(1,1,6'h3F,0,0,0,F  ,0);
      add(1,1,6'h3F,0,1,0,FA ,0);
      add(1,1,6'h3F,0,1,0,B  ,0);
      add(1,1,6'h3F,1,1,1,FT1,0);
      add(1,1,6'h3F,1,1,1,FT1,0);
      // reset, lw with dmem timeout
      add(0,1,6'h23,0,1,0,IDL,0);
      add(1,1,6'h23,0,1,0,IDL,0);
      add(1,1,6'h23,0,1,0,FA ,0);
      add(1,1,6'h23,0,1,0,B  ,0);
      add(1,1,6'h23,0,1,0,B  ,0);
      add(1,1,6'h23,0,0,0,ML ,0);
      add(1,1,6'h23,0,0,0,ML ,0);
      add(1,1,6'h23,0,0,0,ML ,0);
      add(1,1,6'h23,0,0,0,ML ,0);
      add(1,1,6'h23,0,0,0,FT3,0);

      rstn = 1'b0; run = 1'b0; opecode = '0; branch_taken = 1'b0;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rstn = vecs[i].rn; run = vecs[i].run; opecode = vecs[i].op;
         branch_taken = vecs[i].bt; imem_ack = vecs[i].ia; dmem_ack = vecs[i].da;
         @(negedge clk);
         check("outputs", i, got, vecs[i].exp);
         check("instret", i, {12'd0, instret}, {12'd0, vecs[i].ic});
         check("req_exclusive", i, {14'd0, imem_req & dmem_req}, 15'd0);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a fetch handshake.
      rstn = 1'b0; run = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1; run = 1'b1; opecode = 6'h00; imem_ack = 1'b1; dmem_ack = 1'b0;
      @(posedge clk); #1;                 // FETCH, acked
      @(posedge clk); #1;                 // DECODE
      imem_ack = 1'b0;
      @(posedge clk); #1;                 // EXEC
      @(posedge clk); #1;                 // WB
      @(posedge clk); #1;                 // FETCH, waiting
      check("midfetch_req", 100, {14'd0, imem_req}, 15'd1);
      check("midfetch_instret", 100, {12'd0, instret}, 15'd1);
      #2 rstn = 1'b0;
      #1;
      check("rst_req_drop", 101, {14'd0, imem_req}, 15'd0);
      check("rst_instret", 101, {12'd0, instret}, 15'd0);
      check("rst_outputs", 101, got, IDL);
      @(posedge clk); #1;
      rstn = 1'b1; run = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 102, got, IDL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
